// File: rtl/execute_cycle_pkg.sv
// Shared types for the execute stage: ALU opcodes, forwarding selects,
// the bubble instruction and the execute->memory pipeline register layout.
package execute_cycle_pkg;

   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_PASS = 4'd10
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2,
      FWD_NONE = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] rs2_data;
      logic [31:0] alu_data;
      logic        br_equal;
      logic        br_less;
      logic        lsu_wren;
      logic [2:0]  slt_sl;
      logic [1:0]  wb_sel;
      logic        rd_wren;
   } ex_mem_t;

endpackage

// File: rtl/execute_cycle_alu_32.sv
// Combinational 32-bit ALU; unassigned opcodes produce zero.
module alu_32
   import execute_cycle_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  alu_op_e     op_i,
   output logic [31:0] result_o
);

   always_comb begin
      result_o = '0;
      case (op_i)
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_SLL:  result_o = a_i << b_i[4:0];
         ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
         ALU_SLTU: result_o = {31'd0, a_i < b_i};
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_SRL:  result_o = a_i >> b_i[4:0];
         ALU_SRA:  result_o = $signed(a_i) >>> b_i[4:0];
         ALU_OR:   result_o = a_i | b_i;
         ALU_AND:  result_o = a_i & b_i;
         ALU_PASS: result_o = b_i;
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch compare and the
// execute->memory pipeline register with stall/flush control.
module execute_cycle
   import execute_cycle_pkg::*;
#(
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_ex_inst,
   input  logic [31:0] i_ex_pc,
   input  logic [31:0] i_ex_rs1_data,
   input  logic [31:0] i_ex_rs2_data,
   input  logic [31:0] i_ex_imm,
   input  logic [3:0]  i_ex_alu_op,
   input  logic        i_ex_a_sel,
   input  logic        i_ex_b_sel,
   input  logic        i_ex_br_unsigned,
   input  logic        i_ex_lsu_wren,
   input  logic [2:0]  i_ex_slt_sl,
   input  logic [1:0]  i_ex_wb_sel,
   input  logic        i_ex_rd_wren,
   input  logic [1:0]  i_fwd_a_sel,
   input  logic [1:0]  i_fwd_b_sel,
   input  logic [31:0] i_fwd_mem_data,
   input  logic [31:0] i_fwd_wb_data,
   input  logic        i_stall,
   input  logic        i_flush,
   output logic [31:0] o_ex_inst_mem,
   output logic [31:0] o_ex_pc_mem,
   output logic [31:0] o_ex_rs2_data_mem,
   output logic [31:0] o_ex_alu_data_mem,
   output logic        o_ex_br_equal_mem,
   output logic        o_ex_br_less_mem,
   output logic        o_ex_lsu_wren_mem,
   output logic [2:0]  o_ex_slt_sl_mem,
   output logic [1:0]  o_ex_wb_sel_mem,
   output logic        o_ex_rd_wren_mem,
   output logic [4:0]  o_ex_rd_addr_fwd
);

   ex_mem_t     mem_q, mem_d;
   logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_res;

   function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] rf,
                                           input logic [31:0] mem, input logic [31:0] wb);
      case (fwd_sel_e'(sel))
         FWD_RF:  return rf;
         FWD_MEM: return mem;
         FWD_WB:  return wb;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      rs1_fwd = fwd_mux(i_fwd_a_sel, i_ex_rs1_data, i_fwd_mem_data, i_fwd_wb_data);
      rs2_fwd = fwd_mux(i_fwd_b_sel, i_ex_rs2_data, i_fwd_mem_data, i_fwd_wb_data);
      op_a    = i_ex_a_sel ? i_ex_pc  : rs1_fwd;
      op_b    = i_ex_b_sel ? i_ex_imm : rs2_fwd;
   end

   alu_32 u_alu (
      .a_i      (op_a),
      .b_i      (op_b),
      .op_i     (alu_op_e'(i_ex_alu_op)),
      .result_o (alu_res)
   );

   // Flush outranks stall so a squashed instruction never lingers in a held stage.
   always_comb begin
      mem_d = mem_q;
      if (i_flush) begin
         mem_d      = '0;
         mem_d.inst = NOP_INST;
      end else if (!i_stall) begin
         mem_d.inst     = i_ex_inst;
         mem_d.pc       = i_ex_pc;
         mem_d.rs2_data = rs2_fwd;
         mem_d.alu_data = alu_res;
         mem_d.br_equal = (rs1_fwd == rs2_fwd);
         mem_d.br_less  = i_ex_br_unsigned ? (rs1_fwd < rs2_fwd)
                                           : ($signed(rs1_fwd) < $signed(rs2_fwd));
         mem_d.lsu_wren = i_ex_lsu_wren;
         mem_d.slt_sl   = i_ex_slt_sl;
         mem_d.wb_sel   = i_ex_wb_sel;
         mem_d.rd_wren  = i_ex_rd_wren;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         mem_q      <= '0;
         mem_q.inst <= NOP_INST;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign o_ex_inst_mem     = mem_q.inst;
   assign o_ex_pc_mem       = mem_q.pc;
   assign o_ex_rs2_data_mem = mem_q.rs2_data;
   assign o_ex_alu_data_mem = mem_q.alu_data;
   assign o_ex_br_equal_mem = mem_q.br_equal;
   assign o_ex_br_less_mem  = mem_q.br_less;
   assign o_ex_lsu_wren_mem = mem_q.lsu_wren;
   assign o_ex_slt_sl_mem   = mem_q.slt_sl;
   assign o_ex_wb_sel_mem   = mem_q.wb_sel;
   assign o_ex_rd_wren_mem  = mem_q.rd_wren;
   assign o_ex_rd_addr_fwd  = i_ex_inst[11:7];

endmodule
